// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 / interrupt controller.
//   - CP0 register indices as seen in the rd field of mfc0/mtc0
//   - bit positions inside SR and Cause
//   - ExcCode values used by the pipeline
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IE     = 0;
    localparam int EXL    = 1;
    localparam int EXC_LO = 2;
    localparam int IM_LO  = 10;
    localparam int BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: one hardware interrupt line.
//   Synchronises the raw line through SYNC_STAGES flops (0 = pass-through),
//   then either presents it as a level request or, with EDGE=1, turns each
//   0->1 transition of the synchronised value into a sticky pending bit that
//   is cleared by clr. A rise and a clear in the same cycle leave the bit set.
// Ports:
//   clk, reset (async, active-low)
//   line  raw device request
//   clr   acknowledge for the pending bit (ignored for level lines)
//   ip    interrupt-pending value feeding Cause.IP
module int_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    input  logic clr,
    output logic ip
);

    logic synced;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign synced = line;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= line;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign synced = sync_q[SYNC_STAGES-1];
        end

        if (EDGE) begin : g_edge
            logic prev_q, pend_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    prev_q <= 1'b0;
                    pend_q <= 1'b0;
                end else begin
                    prev_q <= synced;
                    // set term is OR'ed last so a simultaneous ack never drops an edge
                    pend_q <= (pend_q & ~clr) | (synced & ~prev_q);
                end
            end
            assign ip = pend_q;
        end else begin : g_level
            logic unused_clr;
            assign unused_clr = clr;
            assign ip         = synced;
        end
    endgenerate

endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: coprocessor 0 with integrated interrupt controller, beside the M stage.
//   Holds SR, Cause, EPC and PRId, synchronises N_HWINT device lines
//   (level or sticky-edge per EDGE_MASK), arbitrates interrupts over internal
//   exceptions and raises take_exc to flush F..M and redirect to the handler.
// Ports:
//   clk, reset (async, active-low)
//   hw_int    device interrupt requests
//   a_sel     CP0 register index (rd of the M instruction)
//   din, we   mtc0 data / strobe
//   pc_m,bd_m PC of the M instruction and its delay-slot flag
//   exc_code  internal exception code, 0 = none
//   exl_clr   eret in M
//   take_exc  exception/interrupt accepted this cycle
//   epc       EPC contents
//   dout      mfc0 read data (pre-update value)
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int          N_HWINT     = 6,
    parameter logic [5:0]  EDGE_MASK   = 6'b000000,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] PRID        = 32'h0000_4350
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_HWINT-1:0] hw_int,
    input  logic [4:0]         a_sel,
    input  logic [31:0]        din,
    input  logic               we,
    input  logic [31:0]        pc_m,
    input  logic               bd_m,
    input  logic [4:0]         exc_code,
    input  logic               exl_clr,
    output logic               take_exc,
    output logic [31:0]        epc,
    output logic [31:0]        dout
);

    logic [N_HWINT-1:0] im_q, ip, clr;
    logic               exl_q, ie_q, bd_q;
    logic [4:0]         code_q;
    logic [31:0]        epc_q;
    logic               int_req, exc_req;
    logic               wr_sr, wr_cause, wr_epc;
    logic [31:0]        pc_adj, sr_val, cause_val;
    logic [1:0]         unused_pc;

    // An accepted exception kills the M instruction, so its mtc0 is dropped.
    assign wr_sr    = we & ~take_exc & (a_sel == REG_SR);
    assign wr_cause = we & ~take_exc & (a_sel == REG_CAUSE);
    assign wr_epc   = we & ~take_exc & (a_sel == REG_EPC);

    genvar i;
    generate
        for (i = 0; i < N_HWINT; i++) begin : g_line
            // W1C only reaches edge lines; level lines follow the device.
            assign clr[i] = wr_cause & din[IM_LO+i] & EDGE_MASK[i];
            int_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES),
                .EDGE       (EDGE_MASK[i])
            ) u_line (
                .clk  (clk),
                .reset(reset),
                .line (hw_int[i]),
                .clr  (clr[i]),
                .ip   (ip[i])
            );
        end
    endgenerate

    assign int_req  = ie_q & ~exl_q & |(ip & im_q);
    assign exc_req  = (exc_code != 5'd0) & ~exl_q;
    assign take_exc = int_req | exc_req;

    // Restart point: a delay-slot instruction restarts at its branch.
    assign pc_adj    = bd_m ? (pc_m - 32'd4) : pc_m;
    assign unused_pc = pc_adj[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
        end else begin
            if (wr_sr) begin
                im_q <= din[IM_LO +: N_HWINT];
                ie_q <= din[IE];
            end
            if (take_exc)     exl_q <= 1'b1;
            else if (exl_clr) exl_q <= 1'b0;
            else if (wr_sr)   exl_q <= din[EXL];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bd_q   <= 1'b0;
            code_q <= EXC_INT;
            epc_q  <= '0;
        end else if (take_exc) begin
            bd_q   <= bd_m;
            code_q <= int_req ? EXC_INT : exc_code;
            epc_q  <= {pc_adj[31:2], 2'b00};
        end else if (wr_epc) begin
            epc_q  <= {din[31:2], 2'b00};
        end
    end

    assign epc = epc_q;

    always_comb begin
        sr_val                     = '0;
        sr_val[IM_LO +: N_HWINT]   = im_q;
        sr_val[EXL]                = exl_q;
        sr_val[IE]                 = ie_q;
        cause_val                  = '0;
        cause_val[BD]              = bd_q;
        cause_val[IM_LO +: N_HWINT] = ip;
        cause_val[EXC_LO +: 5]     = code_q;
        dout                       = '0;
        case (a_sel)
            REG_SR:    dout = sr_val;
            REG_CAUSE: dout = cause_val;
            REG_EPC:   dout = epc_q;
            REG_PRID:  dout = PRID;
            default:   dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed scenarios plus a randomized run against a
// cycle-level reference model of the architectural CP0 state.
module tb_cp0_intc;
    import cp0_pkg::*;

    localparam int          S    = 2;
    localparam logic [5:0]  EM   = 6'b001000;
    localparam logic [31:0] PRID_V = 32'h0000_4350;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hw_int;
    logic [4:0]  a_sel;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code;
    logic        exl_clr;
    logic        take_exc;
    logic [31:0] epc;
    logic [31:0] dout;

    int checks = 0;
    int passed = 0;

    cp0_intc #(.N_HWINT(6), .EDGE_MASK(EM), .SYNC_STAGES(S), .PRID(PRID_V)) dut (
        .clk(clk), .reset(reset), .hw_int(hw_int), .a_sel(a_sel), .din(din), .we(we),
        .pc_m(pc_m), .bd_m(bd_m), .exc_code(exc_code), .exl_clr(exl_clr),
        .take_exc(take_exc), .epc(epc), .dout(dout)
    );

    always #5 clk = ~clk;

    // Reference model: architectural fields plus the history of hw_int as
    // seen at each clock edge (hist[0] = most recent edge).
    logic [5:0]  m_im, m_pend;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic [5:0]  hist [0:7];

    function automatic logic [5:0] m_ip();
        // level lines show the line value from S edges ago; edge lines the latch
        return (EM & m_pend) | (~EM & hist[S-1]);
    endfunction

    function automatic logic m_int();
        return m_ie & ~m_exl & (|(m_ip() & m_im));
    endfunction

    function automatic logic m_take();
        return m_int() | ((exc_code != 5'd0) & ~m_exl);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] sel);
        case (sel)
            5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'b0, m_ip(), 3'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_im = '0; m_pend = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
        m_code = '0; m_epc = '0;
        for (int k = 0; k < 8; k++) hist[k] = '0;
    endtask

    task automatic idle();
        a_sel = 5'd0; din = '0; we = 1'b0; pc_m = '0; bd_m = 1'b0;
        exc_code = '0; exl_clr = 1'b0;
    endtask

    // Advance one clock: update the model from the current inputs, then
    // step to the next falling edge where new inputs are applied.
    task automatic tick();
        logic       t, ireq;
        logic [5:0] rise, ack;
        ireq = m_int();
        t    = m_take();
        rise = hist[S-1] & ~hist[S] & EM;
        ack  = (we && !t && a_sel == REG_CAUSE) ? (din[15:10] & EM) : 6'b0;
        m_pend = (m_pend & ~ack) | rise;
        if (t) begin
            m_exl  = 1'b1;
            m_code = ireq ? EXC_INT : exc_code;
            m_bd   = bd_m;
            m_epc  = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'h3;
        end else begin
            if (we && a_sel == REG_SR) begin
                m_im = din[15:10]; m_ie = din[0]; m_exl = din[1];
            end
            if (exl_clr) m_exl = 1'b0;
            if (we && a_sel == REG_EPC) m_epc = din & ~32'h3;
        end
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = hw_int;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; hw_int = '0; idle(); model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] want [0:4];
        logic [4:0]  sels [0:4];
        do_reset();
        we = 1'b1; a_sel = REG_SR; din = 32'h0000_FC03; tick();
        a_sel = REG_EPC; din = 32'h0000_1237; tick();
        we = 1'b0; a_sel = REG_SR; #1;
        checks++; if (dout !== 32'h0000_FC03) $display("FAIL pre_reset_sr got %h want %h", dout, 32'h0000_FC03); else passed++;
        #1 reset = 1'b0; model_clear(); #1;
        checks++; if (take_exc !== 1'b0) $display("FAIL reset_take got %b want 0", take_exc); else passed++;
        checks++; if (epc !== 32'h0) $display("FAIL reset_epc got %h want 0", epc); else passed++;
        sels[0] = REG_SR; sels[1] = REG_CAUSE; sels[2] = REG_EPC; sels[3] = REG_PRID; sels[4] = 5'd7;
        want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'h0; want[3] = 32'h0000_4350; want[4] = 32'h0;
        for (int k = 0; k < 5; k++) begin
            a_sel = sels[k]; #1;
            checks++; if (dout !== want[k]) $display("FAIL reset_read%0d got %h want %h", sels[k], dout, want[k]); else passed++;
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_level_int();
        do_reset();
        hw_int = 6'b000001; we = 1'b1; a_sel = REG_SR; din = 32'h0000_0401; pc_m = 32'h0000_1000; #1;
        checks++; if (take_exc !== 1'b0) $display("FAIL lvl_early0 got %b want 0", take_exc); else passed++;
        tick();
        we = 1'b0; #1;
        checks++; if (take_exc !== 1'b0) $display("FAIL lvl_early1 got %b want 0", take_exc); else passed++;
        tick(); #1;
        checks++; if (take_exc !== 1'b1) $display("FAIL lvl_take got %b want 1", take_exc); else passed++;
        tick();
        a_sel = REG_CAUSE; #1;
        checks++; if (dout !== 32'h0000_0400) $display("FAIL lvl_cause got %h want %h", dout, 32'h0000_0400); else passed++;
        checks++; if (epc !== 32'h0000_1000) $display("FAIL lvl_epc got %h want %h", epc, 32'h0000_1000); else passed++;
        checks++; if (take_exc !== 1'b0) $display("FAIL lvl_exl_blocks got %b want 0", take_exc); else passed++;
        a_sel = REG_SR; #1;
        checks++; if (dout !== 32'h0000_0403) $display("FAIL lvl_sr got %h want %h", dout, 32'h0000_0403); else passed++;
        exl_clr = 1'b1; #1;
        checks++; if (take_exc !== 1'b0) $display("FAIL lvl_eret_cycle got %b want 0", take_exc); else passed++;
        tick();
        exl_clr = 1'b0; #1;
        checks++; if (take_exc !== 1'b1) $display("FAIL lvl_retake got %b want 1", take_exc); else passed++;
        tick();
    endtask

    task automatic test_edge_sticky();
        do_reset();
        we = 1'b1; a_sel = REG_SR; din = 32'h0000_0001; hw_int = 6'b001000; tick();
        we = 1'b0; hw_int = '0; tick(); tick();
        a_sel = REG_CAUSE; #1;
        checks++; if (dout !== 32'h0000_2000) $display("FAIL edge_ip_set got %h want %h", dout, 32'h0000_2000); else passed++;
        tick(); tick(); #1;
        checks++; if (dout !== 32'h0000_2000) $display("FAIL edge_ip_sticky got %h want %h", dout, 32'h0000_2000); else passed++;
        checks++; if (take_exc !== 1'b0) $display("FAIL edge_masked got %b want 0", take_exc); else passed++;
        we = 1'b1; a_sel = REG_SR; din = 32'h0000_2001; tick();
        we = 1'b0; #1;
        checks++; if (take_exc !== 1'b1) $display("FAIL edge_take got %b want 1", take_exc); else passed++;
        tick();
        we = 1'b1; a_sel = REG_CAUSE; din = 32'h0000_2000; tick();
        we = 1'b0; #1;
        checks++; if (dout !== 32'h0000_0000) $display("FAIL edge_w1c got %h want %h", dout, 32'h0); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        we = 1'b1; a_sel = REG_SR; din = 32'h0000_0801; hw_int = 6'b000010; tick();
        we = 1'b0; tick();
        exc_code = EXC_OV; pc_m = 32'h0000_2000; #1;
        checks++; if (take_exc !== 1'b1) $display("FAIL prio_take1 got %b want 1", take_exc); else passed++;
        tick();
        exc_code = '0; a_sel = REG_CAUSE; #1;
        checks++; if (dout !== 32'h0000_0800) $display("FAIL prio_int_wins got %h want %h", dout, 32'h0000_0800); else passed++;
        do_reset();
        we = 1'b1; a_sel = REG_SR; din = 32'h0000_0001; hw_int = 6'b000010; tick();
        we = 1'b0; tick();
        exc_code = EXC_OV; #1;
        checks++; if (take_exc !== 1'b1) $display("FAIL prio_take2 got %b want 1", take_exc); else passed++;
        tick();
        exc_code = '0; a_sel = REG_CAUSE; #1;
        checks++; if (dout !== 32'h0000_0830) $display("FAIL prio_exc_code got %h want %h", dout, 32'h0000_0830); else passed++;
    endtask

    task automatic test_bd_slot();
        do_reset();
        bd_m = 1'b1; pc_m = 32'h0000_3008; exc_code = EXC_RI;
        we = 1'b1; a_sel = REG_SR; din = 32'h0000_FC01; #1;
        checks++; if (take_exc !== 1'b1) $display("FAIL bd_take got %b want 1", take_exc); else passed++;
        tick();
        idle(); #1;
        checks++; if (epc !== 32'h0000_3004) $display("FAIL bd_epc got %h want %h", epc, 32'h0000_3004); else passed++;
        a_sel = REG_CAUSE; #1;
        checks++; if (dout !== 32'h8000_0028) $display("FAIL bd_cause got %h want %h", dout, 32'h8000_0028); else passed++;
        a_sel = REG_SR; #1;
        checks++; if (dout !== 32'h0000_0002) $display("FAIL bd_sr_write_dropped got %h want %h", dout, 32'h0000_0002); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        hw_int = 6'b001000; tick();
        hw_int = '0; tick();
        we = 1'b1; a_sel = REG_CAUSE; din = 32'h0000_2000; tick();
        we = 1'b0; #1;
        checks++; if (dout !== 32'h0000_2000) $display("FAIL set_beats_w1c got %h want %h", dout, 32'h0000_2000); else passed++;
        we = 1'b1; tick();
        we = 1'b0; #1;
        checks++; if (dout !== 32'h0000_0000) $display("FAIL w1c_alone got %h want %h", dout, 32'h0); else passed++;
        we = 1'b1; a_sel = REG_SR; din = 32'h0000_0002; tick();
        we = 1'b0; exc_code = EXC_ADES; #1;
        checks++; if (take_exc !== 1'b0) $display("FAIL exl_gates_exc got %b want 0", take_exc); else passed++;
        exc_code = '0;
    endtask

    task automatic test_random();
        logic [4:0]  codes [0:7];
        logic [4:0]  sels  [0:5];
        logic [31:0] want;
        codes[0] = EXC_INT; codes[1] = EXC_INT; codes[2] = EXC_INT; codes[3] = EXC_INT;
        codes[4] = EXC_ADEL; codes[5] = EXC_ADES; codes[6] = EXC_RI; codes[7] = EXC_OV;
        sels[0] = REG_SR; sels[1] = REG_CAUSE; sels[2] = REG_EPC; sels[3] = REG_PRID;
        sels[4] = REG_CAUSE; sels[5] = REG_SR;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) hw_int = 6'($urandom);
            a_sel    = ($urandom_range(7) == 0) ? 5'($urandom) : sels[$urandom_range(5)];
            din      = $urandom;
            if ($urandom_range(1) == 0) din[1] = 1'b0;
            pc_m     = $urandom;
            bd_m     = 1'($urandom);
            exc_code = codes[$urandom_range(7)];
            we       = ($urandom_range(3) == 0);
            exl_clr  = !we && ($urandom_range(5) == 0);
            #1;
            checks++; if (take_exc !== m_take()) $display("FAIL rnd_take@%0d got %b want %b", n, take_exc, m_take()); else passed++;
            want = m_read(a_sel);
            checks++; if (dout !== want) $display("FAIL rnd_dout@%0d sel %0d got %h want %h", n, a_sel, dout, want); else passed++;
            checks++; if (epc !== m_epc) $display("FAIL rnd_epc@%0d got %h want %h", n, epc, m_epc); else passed++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; hw_int = '0; idle(); model_clear();
        @(negedge clk);
        test_reset();
        test_level_int();
        test_edge_sticky();
        test_priority();
        test_bd_slot();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
